// File: rtl/collision_pkg.sv
// ============================================================================
// Module      : collision_pkg
// Description : Shared types and helpers for the ball collision detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package collision_pkg;

    localparam int unsigned c_flag_white_border = 0;
    localparam int unsigned c_flag_red_border   = 1;
    localparam int unsigned c_flag_white_hole   = 2;
    localparam int unsigned c_flag_red_hole     = 3;
    localparam int unsigned c_flag_ball_ball    = 4;
    localparam int unsigned c_num_flags         = 5;

    typedef struct packed {
        logic ball_ball;
        logic red_hole;
        logic white_hole;
        logic red_border;
        logic white_border;
    } collision_flags_t;

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        COLLECT  = 1'b1
    } coll_state_t;

    // Per-pixel event vector from the four (already aligned) draw requests.
    function automatic collision_flags_t detect_events(
        input logic white,
        input logic red,
        input logic border,
        input logic hole
    );
        logic [c_num_flags-1:0] f;
        f                      = '0;
        f[c_flag_white_border] = white & border;
        f[c_flag_red_border]   = red & border;
        f[c_flag_white_hole]   = white & hole;
        f[c_flag_red_hole]     = red & hole;
        f[c_flag_ball_ball]    = white & red;
        return collision_flags_t'(f);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ball_collision_detector_sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with clear; clear+inc loads one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int unsigned      WIDTH = 10,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_count <= '0;
        end else if (clear) begin
            // Clearing and counting in the same cycle seeds the new period.
            r_count <= (inc && (MAX != '0)) ? WIDTH'(1) : '0;
        end else if (inc && (r_count != MAX)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/ball_collision_detector.sv
// ============================================================================
// Module      : ball_collision_detector
// Description : Per-frame ball/border/hole collision accumulation and publish.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_collision_detector
    import collision_pkg::*;
#(
    parameter logic [9:0] OVERLAP_MAX = 10'd1023
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        drawingRequestWhite,
    input  logic        drawingRequestRed,
    input  logic        drawingRequestBorder,
    input  logic        drawingRequestHole,
    output logic        collisionValid,
    output logic [4:0]  collisionFlags,
    output logic [9:0]  overlapCount,
    output logic [10:0] firstOverlapX,
    output logic [10:0] firstOverlapY
);

    coll_state_t      r_state;
    logic [10:0]      r_px_x;
    logic [10:0]      r_px_y;
    collision_flags_t r_acc;
    logic             r_first_seen;
    logic [10:0]      r_first_x;
    logic [10:0]      r_first_y;
    logic             r_valid;
    collision_flags_t r_flags_out;
    logic [9:0]       r_count_out;
    logic [10:0]      r_first_x_out;
    logic [10:0]      r_first_y_out;

    collision_flags_t w_evt;
    collision_flags_t w_evt_gated;
    logic             w_active;
    logic             w_fresh;
    logic             w_bb;
    logic [9:0]       w_count;

    assign w_evt = detect_events(drawingRequestWhite, drawingRequestRed,
                                 drawingRequestBorder, drawingRequestHole);

    // Events count while collecting, or on the SOF cycle itself (they seed
    // the new frame). A SOF or idle WAIT_SOF starts accumulators from zero.
    assign w_active    = (r_state == COLLECT) || startOfFrame;
    assign w_fresh     = (r_state == WAIT_SOF) || startOfFrame;
    assign w_evt_gated = w_active ? w_evt : '0;
    assign w_bb        = w_evt_gated.ball_ball;

    sat_counter #(
        .WIDTH (10),
        .MAX   (OVERLAP_MAX)
    ) u_overlap_cnt (
        .clk    (clk),
        .resetN (resetN),
        .clear  (w_fresh),
        .inc    (w_bb),
        .count  (w_count)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state       <= WAIT_SOF;
            r_px_x        <= '0;
            r_px_y        <= '0;
            r_acc         <= '0;
            r_first_seen  <= 1'b0;
            r_first_x     <= '0;
            r_first_y     <= '0;
            r_valid       <= 1'b0;
            r_flags_out   <= '0;
            r_count_out   <= '0;
            r_first_x_out <= '0;
            r_first_y_out <= '0;
        end else begin
            r_px_x  <= pixelX;
            r_px_y  <= pixelY;
            r_valid <= 1'b0;

            case (r_state)
                WAIT_SOF: begin
                    if (startOfFrame) begin
                        r_state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (startOfFrame) begin
                        r_valid       <= 1'b1;
                        r_flags_out   <= r_acc;
                        r_count_out   <= w_count;
                        r_first_x_out <= r_first_x;
                        r_first_y_out <= r_first_y;
                    end
                end
                default: r_state <= WAIT_SOF;
            endcase

            r_acc <= (w_fresh ? collision_flags_t'('0) : r_acc) | w_evt_gated;

            if (w_fresh) begin
                r_first_seen <= w_bb;
                r_first_x    <= w_bb ? r_px_x : 11'd0;
                r_first_y    <= w_bb ? r_px_y : 11'd0;
            end else if (w_bb && !r_first_seen) begin
                r_first_seen <= 1'b1;
                r_first_x    <= r_px_x;
                r_first_y    <= r_px_y;
            end
        end
    end

    assign collisionValid = r_valid;
    assign collisionFlags = r_flags_out;
    assign overlapCount   = r_count_out;
    assign firstOverlapX  = r_first_x_out;
    assign firstOverlapY  = r_first_y_out;

endmodule

`default_nettype wire

// File: tb/tb_ball_collision_detector.sv
// ============================================================================
// Module      : tb_ball_collision_detector
// Description : Directed self-checking bench for ball_collision_detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ball_collision_detector;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        drawingRequestWhite;
    logic        drawingRequestRed;
    logic        drawingRequestBorder;
    logic        drawingRequestHole;
    logic        collisionValid;
    logic [4:0]  collisionFlags;
    logic [9:0]  overlapCount;
    logic [10:0] firstOverlapX;
    logic [10:0] firstOverlapY;

    int n_checks = 0;
    int n_fail   = 0;

    ball_collision_detector #(
        .OVERLAP_MAX (10'd1023)
    ) dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .pixelX               (pixelX),
        .pixelY               (pixelY),
        .drawingRequestWhite  (drawingRequestWhite),
        .drawingRequestRed    (drawingRequestRed),
        .drawingRequestBorder (drawingRequestBorder),
        .drawingRequestHole   (drawingRequestHole),
        .collisionValid       (collisionValid),
        .collisionFlags       (collisionFlags),
        .overlapCount         (overlapCount),
        .firstOverlapX        (firstOverlapX),
        .firstOverlapY        (firstOverlapY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic w, input logic r, input logic b, input logic h);
        drawingRequestWhite  = w;
        drawingRequestRed    = r;
        drawingRequestBorder = b;
        drawingRequestHole   = h;
    endtask

    task automatic sof_pulse();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic check_pub(input string name, input logic v, input logic [4:0] f,
                             input logic [9:0] c, input logic [10:0] x, input logic [10:0] y);
        n_checks++;
        if ({collisionValid, collisionFlags, overlapCount, firstOverlapX, firstOverlapY} !==
            {v, f, c, x, y}) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b flags=%b cnt=%0d xy=(%0d,%0d) expected valid=%0b flags=%b cnt=%0d xy=(%0d,%0d)",
                     name, collisionValid, collisionFlags, overlapCount, firstOverlapX,
                     firstOverlapY, v, f, c, x, y);
        end
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        set_req(0, 0, 0, 0);
        startOfFrame = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        check_pub("reset_state", 1'b0, 5'b0, 10'd0, 11'd0, 11'd0);
        sof_pulse();
        n_checks++;
        if (collisionValid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_sof_no_valid: got %0b expected 0", collisionValid);
        end
    endtask

    task automatic test_ball_ball();
        pixelX = 11'd100; pixelY = 11'd50;
        tick();
        set_req(1, 1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            pixelX = 11'(100 + i);
            tick();
        end
        set_req(0, 0, 0, 0);
        tick();
        sof_pulse();
        check_pub("ball_ball_publish", 1'b1, 5'b10000, 10'd3, 11'd100, 11'd50);
        tick();
        check_pub("ball_ball_hold", 1'b0, 5'b10000, 10'd3, 11'd100, 11'd50);
    endtask

    task automatic test_red_hole();
        pixelX = 11'd20; pixelY = 11'd20;
        tick();
        set_req(0, 1, 0, 1);
        pixelX = 11'd21;
        tick();
        set_req(0, 0, 0, 0);
        tick();
        sof_pulse();
        check_pub("red_hole_publish", 1'b1, 5'b01000, 10'd0, 11'd0, 11'd0);
    endtask

    task automatic test_saturation();
        pixelX = 11'd300; pixelY = 11'd200;
        tick();
        set_req(1, 1, 0, 0);
        for (int i = 0; i < 1100; i++) begin
            pixelX = 11'(301 + (i % 500));
            tick();
        end
        set_req(0, 0, 0, 0);
        tick();
        sof_pulse();
        check_pub("saturation_publish", 1'b1, 5'b10000, 10'd1023, 11'd300, 11'd200);
    endtask

    task automatic test_coincident();
        pixelX = 11'd7; pixelY = 11'd9;
        tick();
        pixelX = 11'd8;
        set_req(1, 1, 0, 0);
        sof_pulse();
        set_req(0, 0, 0, 0);
        check_pub("coincident_excluded", 1'b1, 5'b00000, 10'd0, 11'd0, 11'd0);
        tick();
        tick();
        sof_pulse();
        check_pub("coincident_next_frame", 1'b1, 5'b10000, 10'd1, 11'd7, 11'd9);
    endtask

    task automatic test_reset_mid_frame();
        pixelX = 11'd40; pixelY = 11'd60;
        tick();
        set_req(1, 0, 1, 0);
        tick();
        set_req(0, 0, 0, 0);
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        check_pub("mid_reset_cleared", 1'b0, 5'b0, 10'd0, 11'd0, 11'd0);
        tick();
        sof_pulse();
        check_pub("mid_reset_no_valid", 1'b0, 5'b0, 10'd0, 11'd0, 11'd0);
        tick();
        tick();
        sof_pulse();
        check_pub("mid_reset_publish", 1'b1, 5'b0, 10'd0, 11'd0, 11'd0);
    endtask

    task automatic test_back_to_back();
        int pulses;
        do_reset();
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            startOfFrame = (c == 0 || c == 2 || c == 4);
            tick();
            if (collisionValid === 1'b1) begin
                pulses++;
                n_checks++;
                if (collisionFlags !== 5'b0) begin
                    n_fail++;
                    $display("FAIL b2b_flags: got %b expected 00000", collisionFlags);
                end
            end
        end
        startOfFrame = 1'b0;
        n_checks++;
        if (pulses !== 2) begin
            n_fail++;
            $display("FAIL b2b_pulse_count: got %0d expected 2", pulses);
        end
        // Truly consecutive SOF cycles must each publish.
        startOfFrame = 1'b1;
        tick();
        check_pub("consecutive_sof_1", 1'b1, 5'b0, 10'd0, 11'd0, 11'd0);
        tick();
        startOfFrame = 1'b0;
        check_pub("consecutive_sof_2", 1'b1, 5'b0, 10'd0, 11'd0, 11'd0);
        tick();
        check_pub("consecutive_sof_end", 1'b0, 5'b0, 10'd0, 11'd0, 11'd0);
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        pixelX       = '0;
        pixelY       = '0;
        set_req(0, 0, 0, 0);
        test_reset();
        test_ball_ball();
        test_red_hole();
        test_saturation();
        test_coincident();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ball_collision_detector.md
BALL_COLLISION_DETECTOR -- requirements
Module: ball_collision_detector

Interface
REQ-001 The block SHALL have parameter OVERLAP_MAX, default 10'd1023, the saturation value of the ball-ball overlap pixel counter.
REQ-002 clk  in  1  system clock; one clock domain, all logic on its rising edge.
REQ-003 resetN  in  1  reset, synchronous and active-low.
REQ-004 startOfFrame  in  1  one-cycle pulse marking the first pixel of a new frame.
REQ-005 pixelX  in  11  current scan X; same timing as the pixelX fed to the draw blocks.
REQ-006 pixelY  in  11  current scan Y; same timing as the pixelY fed to the draw blocks.
REQ-007 drawingRequestWhite  in  1  white-ball draw request; registered, so it lags pixelX/Y by one clock.
REQ-008 drawingRequestRed  in  1  red-ball draw request; same one-clock lag.
REQ-009 drawingRequestBorder  in  1  table-cushion draw request; same one-clock lag.
REQ-010 drawingRequestHole  in  1  pocket draw request; same one-clock lag.
REQ-011 collisionValid  out  1  one-cycle pulse: the published results of the completed frame are valid.
REQ-012 collisionFlags  out  5  {ballBall, redHole, whiteHole, redBorder, whiteBorder}, held between publishes.
REQ-013 overlapCount  out  10  number of ball-ball overlap pixels in the last frame, saturating.
REQ-014 firstOverlapX  out  11  X of the first ball-ball overlap pixel of the last frame, held.
REQ-015 firstOverlapY  out  11  Y of the first ball-ball overlap pixel of the last frame, held.

Function
REQ-016 The block SHALL delay pixelX/pixelY by one register stage so that the coordinates align with the draw requests.
REQ-017 Per aligned pixel, the events SHALL be:
  - whiteBorder = White & Border
  - redBorder = Red & Border
  - whiteHole = White & Hole
  - redHole = Red & Hole
  - ballBall = White & Red
REQ-018 Event accumulators SHALL be sticky OR-flags that set on any event pixel within the frame.
REQ-019 The overlap counter SHALL increment on each ballBall pixel and saturate at OVERLAP_MAX; it SHALL never wrap.
REQ-020 On the first ballBall pixel of a frame, the block SHALL capture the aligned X/Y; later overlap pixels in the same frame SHALL NOT overwrite it.
REQ-021 The state machine SHALL have two states:
  - WAIT_SOF: entered on reset; accumulators are held cleared.
  - COLLECT: entered on the first startOfFrame seen in WAIT_SOF.
REQ-022 The WAIT_SOF to COLLECT transition SHALL NOT pulse collisionValid.
REQ-023 On startOfFrame in COLLECT, at the next clock the block SHALL:
  - copy the accumulators, counter and captured X/Y to the outputs;
  - pulse collisionValid high for exactly one cycle;
  - clear all accumulators.
REQ-024 Publish latency SHALL be one clock: collisionValid rises in the cycle after the startOfFrame cycle.
REQ-025 An event on the same aligned cycle as startOfFrame SHALL belong to the new frame; the publish SHALL NOT include it, and it SHALL seed the cleared accumulators.
REQ-026 If no ballBall occurred in a frame, the published firstOverlapX/Y SHALL be 0 and overlapCount SHALL be 0.
REQ-027 Back-to-back startOfFrame pulses SHALL each publish; an empty frame publishes all-zero flags.
REQ-028 Outputs SHALL hold their published values until the next publish or reset.

Reset
REQ-029 While resetN=0 at a clock edge, the block SHALL:
  - enter WAIT_SOF;
  - drive collisionValid=0, collisionFlags=5'b0, overlapCount=0, firstOverlapX/Y=0;
  - clear all accumulators and the pixel delay stage.
REQ-030 A reset mid-frame SHALL discard partial results; no publish occurs until one full frame is collected after the next startOfFrame.

Structure
REQ-031 The shared package collision_pkg SHALL hold:
  - typedef collision_flags_t (5-bit packed struct in REQ-012 order);
  - state enum coll_state_t {WAIT_SOF, COLLECT};
  - bit-index constants for the flags.
REQ-032 The saturating overlap counter SHALL be one sub-module, sat_counter (parameterised width and max, with clear and increment inputs).

Verification
REQ-033 The bench SHALL cover these directed scenarios:
  - Reset, then SOF, then White=Red=1 at aligned pixel (100,50) for 3 pixels, then SOF: one cycle after SOF, collisionValid=1, flags=5'b10000, overlapCount=3, firstOverlap=(100,50).
  - Red&Hole at pixel (20,20), then SOF: flags=5'b01000, overlapCount=0, firstOverlap=(0,0).
  - 1100 consecutive ballBall pixels in one frame: published overlapCount=1023.
  - Event coincident with aligned SOF: the first publish excludes it; the next publish reports it.
  - resetN=0 mid-frame after White&Border: no collisionValid at the next SOF; the SOF after that publishes flags=0.
  - Three SOFs with no requests: exactly two valid pulses, each with flags=0.
